// File: rtl/decode_pkg.sv
// Shared types, field-position helpers and the control unit for the decode stage.
// Optional write-back bypass in the register file is selected with DECODE_WB_BYPASS_EN.
package decode_pkg;

    localparam int OPTYPE_W = 2;
    localparam int OPCODE_W = 4;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_REG_IDX_W = 4;
    localparam int DEF_INSTR_W   = 32;
    localparam int DEF_IMM_W     = DEF_INSTR_W - OPTYPE_W - OPCODE_W - 2*DEF_REG_IDX_W;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;

    typedef enum logic [OPTYPE_W-1:0] {
        OPT_ALU  = 2'b00,
        OPT_ALUI = 2'b01,
        OPT_MEM  = 2'b10,
        OPT_BR   = 2'b11
    } optype_e;

    typedef struct packed {
        logic       imm_src;
        logic       branch_flag;
        logic       mem_write;
        logic       mem_to_reg;
        logic [3:0] alu_control;
    } ctrl_t;

    typedef struct packed {
        ctrl_t                    ctrl;
        logic [DEF_REG_IDX_W-1:0] ra;
        logic [DEF_REG_IDX_W-1:0] rb;
        logic [DEF_REG_IDX_W-1:0] rc;
        logic [DEF_DATA_W-1:0]    rd1;
        logic [DEF_DATA_W-1:0]    rd2;
        logic [DEF_DATA_W-1:0]    rd3;
        logic [DEF_DATA_W-1:0]    imm;
    } id_ex_t;

    // Field order from the MSB: opType, opCode, Rc, Ra, Rb; imm shares its top bits with Rb.
    function automatic int optype_lsb(input int instr_w);
        return instr_w - OPTYPE_W;
    endfunction

    function automatic int opcode_lsb(input int instr_w);
        return instr_w - OPTYPE_W - OPCODE_W;
    endfunction

    function automatic int rc_lsb(input int instr_w, input int idx_w);
        return opcode_lsb(instr_w) - idx_w;
    endfunction

    function automatic int ra_lsb(input int instr_w, input int idx_w);
        return rc_lsb(instr_w, idx_w) - idx_w;
    endfunction

    function automatic int rb_lsb(input int instr_w, input int idx_w);
        return ra_lsb(instr_w, idx_w) - idx_w;
    endfunction

    function automatic ctrl_t decode_ctrl(input logic [OPTYPE_W-1:0] op_type,
                                          input logic [OPCODE_W-1:0] op_code);
        ctrl_t c;
        c = '0;
        case (optype_e'(op_type))
            OPT_ALU: begin
                c.alu_control = op_code;
            end
            OPT_ALUI: begin
                c.imm_src     = 1'b1;
                c.alu_control = op_code;
            end
            OPT_MEM: begin
                // opCode bit 0 selects store (1) or load (0); address is base + imm
                c.imm_src     = 1'b1;
                c.mem_write   = op_code[0];
                c.mem_to_reg  = ~op_code[0];
                c.alu_control = ALU_ADD;
            end
            OPT_BR: begin
                c.imm_src     = 1'b1;
                c.branch_flag = 1'b1;
                c.alu_control = ALU_SUB;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_hs_regfile.sv
// 3-read/1-write register file with synchronous reset; register 0 is an ordinary register.
// DECODE_WB_BYPASS_EN makes a same-cycle write visible on the read ports.
module regfile_3r1w #(
    parameter int DATA_W    = 32,
    parameter int REG_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] wa,
    input  logic [DATA_W-1:0]    wd,
    input  logic [REG_IDX_W-1:0] ra1,
    input  logic [REG_IDX_W-1:0] ra2,
    input  logic [REG_IDX_W-1:0] ra3,
    output logic [DATA_W-1:0]    rd1,
    output logic [DATA_W-1:0]    rd2,
    output logic [DATA_W-1:0]    rd3
);

    localparam int DEPTH = 2**REG_IDX_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

`ifdef DECODE_WB_BYPASS_EN
    assign rd1 = (we && (ra1 == wa)) ? wd : mem[ra1];
    assign rd2 = (we && (ra2 == wa)) ? wd : mem[ra2];
    assign rd3 = (we && (ra3 == wa)) ? wd : mem[ra3];
`else
    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];
    assign rd3 = mem[ra3];
`endif

endmodule

// File: rtl/decode_stage_hs.sv
// Decode stage with valid/ready on both sides, load-use interlock, flush and a stall counter.
// Write-back bypass through the register file is enabled by defining DECODE_WB_BYPASS_EN.
module decode_stage_hs
    import decode_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_IDX_W = 4,
    parameter int INSTR_W   = 32,
    parameter int IMM_W     = 18,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [INSTR_W-1:0]   in_instr,
    output logic                 in_ready,
    input  logic                 flush,
    input  logic                 wb_we,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]    wb_wd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_ctrl,
    output logic [REG_IDX_W-1:0] out_ra,
    output logic [REG_IDX_W-1:0] out_rb,
    output logic [REG_IDX_W-1:0] out_rc,
    output logic [DATA_W-1:0]    out_rd1,
    output logic [DATA_W-1:0]    out_rd2,
    output logic [DATA_W-1:0]    out_rd3,
    output logic [DATA_W-1:0]    out_imm,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int OPTYPE_LSB = optype_lsb(INSTR_W);
    localparam int OPCODE_LSB = opcode_lsb(INSTR_W);
    localparam int RC_LSB     = rc_lsb(INSTR_W, REG_IDX_W);
    localparam int RA_LSB     = ra_lsb(INSTR_W, REG_IDX_W);
    localparam int RB_LSB     = rb_lsb(INSTR_W, REG_IDX_W);

    if (IMM_W != RB_LSB + REG_IDX_W) begin : g_bad_imm_w
        $error("IMM_W must equal INSTR_W-6-2*REG_IDX_W");
    end
    if (DATA_W <= IMM_W) begin : g_bad_data_w
        $error("DATA_W must exceed IMM_W for sign extension");
    end

    typedef struct packed {
        ctrl_t                ctrl;
        logic [REG_IDX_W-1:0] ra;
        logic [REG_IDX_W-1:0] rb;
        logic [REG_IDX_W-1:0] rc;
        logic [DATA_W-1:0]    rd1;
        logic [DATA_W-1:0]    rd2;
        logic [DATA_W-1:0]    rd3;
        logic [DATA_W-1:0]    imm;
    } payload_t;

    logic [OPTYPE_W-1:0]  f_optype;
    logic [OPCODE_W-1:0]  f_opcode;
    logic [REG_IDX_W-1:0] f_rc;
    logic [REG_IDX_W-1:0] f_ra;
    logic [REG_IDX_W-1:0] f_rb;
    logic [IMM_W-1:0]     f_imm;
    ctrl_t                dec_ctrl;
    logic [DATA_W-1:0]    rf_rd1;
    logic [DATA_W-1:0]    rf_rd2;
    logic [DATA_W-1:0]    rf_rd3;
    payload_t             dec;
    payload_t             q;
    logic                 q_valid;
    logic                 src_match;
    logic                 hazard;
    logic                 accept;
    logic [CNT_W-1:0]     stall_q;

    assign f_optype = in_instr[OPTYPE_LSB +: OPTYPE_W];
    assign f_opcode = in_instr[OPCODE_LSB +: OPCODE_W];
    assign f_rc     = in_instr[RC_LSB +: REG_IDX_W];
    assign f_ra     = in_instr[RA_LSB +: REG_IDX_W];
    assign f_rb     = in_instr[RB_LSB +: REG_IDX_W];
    assign f_imm    = in_instr[IMM_W-1:0];
    assign dec_ctrl = decode_ctrl(f_optype, f_opcode);

    regfile_3r1w #(
        .DATA_W    (DATA_W),
        .REG_IDX_W (REG_IDX_W)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .we  (wb_we),
        .wa  (wb_rd),
        .wd  (wb_wd),
        .ra1 (f_ra),
        .ra2 (f_rb),
        .ra3 (f_rc),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .rd3 (rf_rd3)
    );

    always_comb begin
        dec      = '0;
        dec.ctrl = dec_ctrl;
        dec.ra   = f_ra;
        dec.rb   = f_rb;
        dec.rc   = f_rc;
        dec.rd1  = rf_rd1;
        dec.rd2  = rf_rd2;
        dec.rd3  = rf_rd3;
        dec.imm  = {{(DATA_W-IMM_W){f_imm[IMM_W-1]}}, f_imm};
    end

    // A load in EX blocks any consumer of its Rc; stores also read Rc as store data.
    assign src_match = (q.rc == f_ra) || (q.rc == f_rb) || (dec_ctrl.mem_write && (q.rc == f_rc));
    assign hazard    = in_valid && q_valid && q.ctrl.mem_to_reg && src_match;
    assign in_ready  = !rst && !hazard && !flush && (!q_valid || out_ready);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q       <= '0;
        end else if (flush) begin
            q_valid <= 1'b0;
        end else if (accept) begin
            q_valid <= 1'b1;
            q       <= dec;
        end else if (out_ready) begin
            q_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (hazard && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign out_valid = q_valid;
    assign out_ctrl  = q.ctrl;
    assign out_ra    = q.ra;
    assign out_rb    = q.rb;
    assign out_rc    = q.rc;
    assign out_rd1   = q.rd1;
    assign out_rd2   = q.rd2;
    assign out_rd3   = q.rd3;
    assign out_imm   = q.imm;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed self-checking bench for decode_stage_hs; bypass expectations follow DECODE_WB_BYPASS_EN.
module tb_decode_stage_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_ctrl;
    logic [3:0]  out_ra;
    logic [3:0]  out_rb;
    logic [3:0]  out_rc;
    logic [31:0] out_rd1;
    logic [31:0] out_rd2;
    logic [31:0] out_rd3;
    logic [31:0] out_imm;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage_hs dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_wd     (wb_wd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_ra    (out_ra),
        .out_rb    (out_rb),
        .out_rc    (out_rc),
        .out_rd1   (out_rd1),
        .out_rd2   (out_rd2),
        .out_rd3   (out_rd3),
        .out_imm   (out_imm),
        .stall_cnt (stall_cnt)
    );

    function automatic logic [31:0] enc(input logic [1:0] ot, input logic [3:0] oc,
                                        input logic [3:0] rc, input logic [3:0] ra,
                                        input logic [17:0] imm);
        return {ot, oc, rc, ra, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wr_reg(input logic [3:0] idx, input logic [31:0] val);
        wb_we = 1'b1;
        wb_rd = idx;
        wb_wd = val;
        step();
        wb_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr_reg(4'd5, 32'h0000_0055);
        in_instr  = enc(2'b00, 4'h0, 4'd0, 4'd5, 18'h0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_rd1 !== 32'h55) begin
            n_fail++;
            $display("FAIL pre_reset_rd1: got %h want %h", out_rd1, 32'h55);
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        settle();
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        step();
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, stall_cnt} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_valid_stall: got valid=%b stall=%0d want 0/0", out_valid, stall_cnt);
        end
        n_tests++;
        if ({out_ctrl, out_ra, out_rd1, out_imm} !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: got ctrl=%h ra=%h rd1=%h imm=%h want 0", out_ctrl, out_ra, out_rd1, out_imm);
        end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, out_rd1} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_r5_read: got valid=%b rd1=%h want 1/00000000", out_valid, out_rd1);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr [3];
        logic [11:0] exp_idx [3];
        logic [95:0] exp_rd [3];
        logic [7:0]  exp_ctrl [3];
        wr_reg(4'd1, 32'h11);
        wr_reg(4'd2, 32'h22);
        wr_reg(4'd15, 32'hFF);
        instr[0] = enc(2'b00, 4'h3, 4'd1, 4'd2, 18'h3FFFF);
        instr[1] = enc(2'b00, 4'h5, 4'd4, 4'd1, 18'h3FFFF);
        instr[2] = enc(2'b01, 4'h2, 4'd6, 4'd15, 18'h3FFFF);
        exp_idx[0] = {4'd2, 4'd15, 4'd1};
        exp_idx[1] = {4'd1, 4'd15, 4'd4};
        exp_idx[2] = {4'd15, 4'd15, 4'd6};
        exp_rd[0]  = {32'h22, 32'hFF, 32'h11};
        exp_rd[1]  = {32'h11, 32'hFF, 32'h0};
        exp_rd[2]  = {32'hFF, 32'hFF, 32'h0};
        exp_ctrl[0] = 8'h03;
        exp_ctrl[1] = 8'h05;
        exp_ctrl[2] = 8'h82;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_instr = instr[i];
            settle();
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready);
            end
            step();
            n_tests++;
            if ({out_valid, out_ra, out_rb, out_rc, out_ctrl, out_imm} !== {1'b1, exp_idx[i], exp_ctrl[i], 32'hFFFF_FFFF}) begin
                n_fail++;
                $display("FAIL b2b_fields[%0d]: got v=%b idx=%h ctrl=%h imm=%h want 1 %h %h ffffffff",
                         i, out_valid, {out_ra, out_rb, out_rc}, out_ctrl, out_imm, exp_idx[i], exp_ctrl[i]);
            end
            n_tests++;
            if ({out_rd1, out_rd2, out_rd3} !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL b2b_operands[%0d]: got %h want %h", i, {out_rd1, out_rd2, out_rd3}, exp_rd[i]);
            end
        end
        in_valid = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] ld;
        ld        = enc(2'b10, 4'h0, 4'd3, 4'd1, 18'h00010);
        out_ready = 1'b1;
        in_instr  = ld;
        in_valid  = 1'b1;
        step();
        in_instr = enc(2'b00, 4'h1, 4'd2, 4'd3, 18'h0);
        settle();
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_stall_ready: got %b want 0", in_ready);
        end
        step();
        n_tests++;
        if ({out_valid, stall_cnt} !== {1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL lu_bubble: got valid=%b stall=%0d want 0/1", out_valid, stall_cnt);
        end
        settle();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_release_ready: got %b want 1", in_ready);
        end
        step();
        n_tests++;
        if ({out_valid, out_ra, out_ctrl, stall_cnt} !== {1'b1, 4'd3, 8'h01, 16'd1}) begin
            n_fail++;
            $display("FAIL lu_accept: got valid=%b ra=%h ctrl=%h stall=%0d want 1 3 01 1", out_valid, out_ra, out_ctrl, stall_cnt);
        end
        in_instr = ld;
        step();
        in_instr = enc(2'b10, 4'h1, 4'd3, 4'd1, 18'h0);
        settle();
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_store_stall: got %b want 0", in_ready);
        end
        step();
        step();
        n_tests++;
        if ({out_valid, out_ctrl, stall_cnt} !== {1'b1, 8'hA0, 16'd2}) begin
            n_fail++;
            $display("FAIL lu_store_accept: got valid=%b ctrl=%h stall=%0d want 1 a0 2", out_valid, out_ctrl, stall_cnt);
        end
        in_instr = ld;
        step();
        in_instr = enc(2'b00, 4'h1, 4'd3, 4'd1, 18'h0);
        settle();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_rc_no_hazard: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, out_rc, out_ctrl, stall_cnt} !== {1'b1, 4'd3, 8'h01, 16'd2}) begin
            n_fail++;
            $display("FAIL lu_rc_accept: got valid=%b rc=%h ctrl=%h stall=%0d want 1 3 01 2", out_valid, out_rc, out_ctrl, stall_cnt);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        in_instr  = enc(2'b00, 4'h6, 4'd7, 4'd8, 18'h12345);
        in_valid  = 1'b1;
        step();
        in_instr  = enc(2'b00, 4'h7, 4'd9, 4'd10, 18'h20000);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_tests++;
            if ({in_ready, out_valid, out_ra, out_rb, out_rc, out_ctrl, out_imm} !==
                {1'b0, 1'b1, 4'd8, 4'd4, 4'd7, 8'h06, 32'h0001_2345}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b idx=%h ctrl=%h imm=%h want 0 1 847 06 00012345",
                         i, in_ready, out_valid, {out_ra, out_rb, out_rc}, out_ctrl, out_imm);
            end
            step();
        end
        out_ready = 1'b1;
        settle();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, out_ra, out_rb, out_rc, out_imm} !== {1'b1, 4'd10, 4'd8, 4'd9, 32'hFFFE_0000}) begin
            n_fail++;
            $display("FAIL bp_next: got v=%b idx=%h imm=%h want 1 a89 fffe0000", out_valid, {out_ra, out_rb, out_rc}, out_imm);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_dup: got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_instr  = enc(2'b00, 4'h6, 4'd7, 4'd8, 18'h12345);
        in_valid  = 1'b1;
        step();
        in_instr  = enc(2'b00, 4'h7, 4'd9, 4'd10, 18'h20000);
        flush     = 1'b1;
        out_ready = 1'b0;
        settle();
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        step();
        flush     = 1'b0;
        out_ready = 1'b1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_kill: got valid=%b want 0", out_valid);
        end
        step();
        n_tests++;
        if ({out_valid, out_ra} !== {1'b1, 4'd10}) begin
            n_fail++;
            $display("FAIL flush_retry: got valid=%b ra=%h want 1 a", out_valid, out_ra);
        end
        in_instr = enc(2'b10, 4'h0, 4'd3, 4'd1, 18'h00010);
        step();
        in_instr = enc(2'b00, 4'h1, 4'd2, 4'd3, 18'h0);
        flush    = 1'b1;
        step();
        flush = 1'b0;
        n_tests++;
        if ({out_valid, stall_cnt} !== {1'b0, 16'd2}) begin
            n_fail++;
            $display("FAIL flush_hazard: got valid=%b stall=%0d want 0/2", out_valid, stall_cnt);
        end
        step();
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, out_ra, stall_cnt} !== {1'b1, 4'd3, 16'd2}) begin
            n_fail++;
            $display("FAIL flush_after: got valid=%b ra=%h stall=%0d want 1 3 2", out_valid, out_ra, stall_cnt);
        end
        step();
    endtask

    task automatic test_bypass();
        logic [31:0] exp_rd1;
`ifdef DECODE_WB_BYPASS_EN
        exp_rd1 = 32'hDEAD_BEEF;
`else
        exp_rd1 = 32'h1234_5678;
`endif
        wr_reg(4'd7, 32'h1234_5678);
        wr_reg(4'd0, 32'h0000_A5A5);
        out_ready = 1'b1;
        in_instr  = enc(2'b00, 4'h0, 4'd0, 4'd7, 18'h0);
        in_valid  = 1'b1;
        wb_we     = 1'b1;
        wb_rd     = 4'd7;
        wb_wd     = 32'hDEAD_BEEF;
        step();
        wb_we = 1'b0;
        n_tests++;
        if (out_rd1 !== exp_rd1) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got %h want %h", out_rd1, exp_rd1);
        end
        n_tests++;
        if (out_rd3 !== 32'h0000_A5A5) begin
            n_fail++;
            $display("FAIL r0_writable: got %h want 0000a5a5", out_rd3);
        end
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_rd1 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: got %h want deadbeef", out_rd1);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        flush     = 1'b0;
        wb_we     = 1'b0;
        wb_rd     = '0;
        wb_wd     = '0;
        out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_backpressure();
        test_flush();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage_hs.md
# decode_stage_hs

Parametrised instruction-decode pipeline stage sitting between fetch and execute. Splits the instruction word, decodes control flags, reads three operands from an internal 3-read/1-write register file and presents them through a registered ID/EX output. Adds what the earlier decode stage lacked: a valid/ready handshake on both sides, a one-bubble load-use interlock, branch flush, optional write-back bypass and a stall counter.

## Interface
- `DATA_W`, 32: register and operand width.
- `REG_IDX_W`, 4: register index width; the file has 2**REG_IDX_W entries.
- `INSTR_W`, 32: instruction width.
- `IMM_W`, 18: immediate width; must equal INSTR_W-6-2*REG_IDX_W.
- `CNT_W`, 16: stall counter width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: `in_instr` holds an instruction.
- `in_instr` in INSTR_W: instruction word.
- `in_ready` out 1: instruction is accepted this cycle when `in_valid && in_ready`.
- `flush` in 1: branch taken; kill the output register and the incoming instruction.
- `wb_we` in 1: write-back write enable.
- `wb_rd` in REG_IDX_W: write-back destination index.
- `wb_wd` in DATA_W: write-back data.
- `out_valid` out 1: ID/EX register holds an instruction.
- `out_ready` in 1: execute consumes the output when `out_valid && out_ready`.
- `out_ctrl` out 8: {immSrc, branchFlag, memWrite, memToReg, aluControl[3:0]}.
- `out_ra`, `out_rb`, `out_rc` out REG_IDX_W each: source and destination indices.
- `out_rd1`, `out_rd2`, `out_rd3` out DATA_W each: operands read at Ra, Rb, Rc.
- `out_imm` out DATA_W: sign-extended immediate.
- `stall_cnt` out CNT_W: count of cycles with a load-use stall.

## Operation
- Instruction fields, MSB first:
  - opType = top 2 bits; opCode = next 4.
  - Rc, then Ra, then Rb, each REG_IDX_W wide.
  - imm = low IMM_W bits. It overlaps Rb by design.
- Control flags come combinationally from opType/opCode through the existing control unit.
- Register file:
  - All entries are written on `clk` when `wb_we` is high.
  - Register 0 is writable; it is not hardwired to zero.
- Hazard:
  - Condition: `in_valid && out_valid && out_ctrl.memToReg && src_match`.
  - src_match = (out_rc==Ra) || (out_rc==Rb) || (memWrite_in && out_rc==Rc).
- `in_ready` = !hazard && !flush && (!out_valid || out_ready).
- Output register update, in priority order:
  1. `rst`: everything cleared.
  2. `flush`: `out_valid`<=0 and the input is not accepted.
  3. Accept: the decoded bundle is loaded and `out_valid`<=1.
  4. `out_ready` with no accept (this covers a hazard or `!in_valid`): `out_valid`<=0, which inserts a bubble.
  5. Otherwise hold.
- Bubble contents: payload fields keep their old values; only `out_valid` drops.
- `stall_cnt` increments in every cycle where hazard=1. It saturates at all-ones.

## Timing
- Latency is 1 cycle from accept to `out_valid`.
- Full throughput is 1 instruction per cycle with no hazards.
- Load-use interlock costs exactly one bubble. After the bubble, the EX slot no longer holds the load, so hazard=0 and the stalled instruction is accepted next cycle.
- `in_ready` is combinational from `out_ready`, `flush` and the inputs. There is no skid buffer.
- Reset values:
  - `out_valid`=0.
  - All `out_*` payload ports = 0.
  - `stall_cnt`=0.
  - All registers = 0.
  - `in_ready`=0 while `rst` is high.
- Reset mid-operation drops the in-flight instruction with no partial state.
- Flush together with hazard or accept: flush wins and `stall_cnt` does not increment.
- Write and read of the same index in one cycle: governed by the macro below.

## Configuration
- `DECODE_WB_BYPASS_EN`:
  - Defined: a read whose index equals `wb_rd` while `wb_we`=1 returns `wb_wd` in the same cycle (write-through).
  - Undefined: the read returns the pre-write value. The new value is visible from the next cycle.

## Structure
- Package `decode_pkg`:
  - Typedef `ctrl_t` (packed 8-bit control flags).
  - Typedef `id_ex_t` (the payload struct).
  - Field-position localparams derived from the parameters.
  - Constant `OPTYPE_W`=2 and `OPCODE_W`=4.
- Sub-module `regfile_3r1w` (params DATA_W, REG_IDX_W) contains the storage, the synchronous reset and the optional bypass.
- Sign extension is inline.

## Test plan
- Reset: hold `rst` 2 cycles, then check `out_valid`=0, `stall_cnt`=0, and that a read of R5 returns 0x0.
- Back-to-back: three independent ALU instructions with `out_ready`=1 give `out_valid` on 3 consecutive cycles with the correct Ra/Rb/Rc and an imm of 0x3FFFF extended to 0xFFFFFFFF.
- Load-use: a load with Rc=3 followed by an ALU instruction with Ra=3 gives one bubble cycle, `in_ready`=0 for 1 cycle, then accept; `stall_cnt`=1.
- Backpressure: `out_ready`=0 for 4 cycles, then check the output holds stable, `in_ready`=0, and nothing is lost or duplicated on release.
- Flush: assert `flush` with `in_valid`=1 and `out_valid`=1; next cycle `out_valid`=0 and the instruction is not consumed.
- Bypass: `wb_we`=1, `wb_rd`=7, `wb_wd`=0xDEADBEEF while decoding Ra=7 gives `out_rd1`=0xDEADBEEF when `DECODE_WB_BYPASS_EN` is defined, and the old value otherwise.
